// File: rtl/scramble_input_ctrl_pkg.sv
// Shared constants, types and helpers for the Scramble input-conditioning stage.
// Scancodes, joystick bit positions, coin FSM states and the player-word packer.
package scramble_input_pkg;

    // Direction keys match on the low byte only; the extended prefix bit is don't-care.
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam logic [8:0] SC_FIRE1    = 9'h014;
    localparam logic [8:0] SC_FIRE2    = 9'h029;
    localparam logic [8:0] SC_START1_A = 9'h005;
    localparam logic [8:0] SC_START1_B = 9'h016;
    localparam logic [8:0] SC_START2_A = 9'h006;
    localparam logic [8:0] SC_START2_B = 9'h01E;
    localparam logic [8:0] SC_COIN1    = 9'h02E;
    localparam logic [8:0] SC_COIN2    = 9'h036;
    localparam logic [8:0] SC_P2_UP    = 9'h02D;
    localparam logic [8:0] SC_P2_DOWN  = 9'h02B;
    localparam logic [8:0] SC_P2_LEFT  = 9'h023;
    localparam logic [8:0] SC_P2_RIGHT = 9'h034;
    localparam logic [8:0] SC_P2_FIRE1 = 9'h01C;
    localparam logic [8:0] SC_P2_FIRE2 = 9'h01B;

    localparam int JOY_RIGHT  = 0;
    localparam int JOY_LEFT   = 1;
    localparam int JOY_DOWN   = 2;
    localparam int JOY_UP     = 3;
    localparam int JOY_FIRE1  = 4;
    localparam int JOY_FIRE2  = 5;
    localparam int JOY_START1 = 6;
    localparam int JOY_START2 = 7;
    localparam int JOY_COIN   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_HOLD  = 2'd3
    } coin_state_e;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic fire1;
        logic fire2;
        logic start1;
        logic start2;
        logic coin1;
        logic coin2;
        logic p2_up;
        logic p2_down;
        logic p2_left;
        logic p2_right;
        logic p2_fire1;
        logic p2_fire2;
    } held_keys_t;

    // Horizontal-screen mode turns the cabinet 90 degrees, so directions rotate before packing.
    function automatic logic [6:0] player_word(input logic up, input logic down,
                                               input logic left, input logic right,
                                               input logic fire1, input logic fire2,
                                               input logic start, input logic rotate);
        logic u, d, l, r;
        u = rotate ? left  : up;
        d = rotate ? right : down;
        l = rotate ? down  : left;
        r = rotate ? up    : right;
        return ~{start, fire2, fire1, l, r, u, d};
    endfunction

endpackage

// File: rtl/scramble_input_ctrl_if.sv
// Bundle of keyboard/joystick inputs and player/coin outputs of the input stage.
// The stage itself sits on the slave side; the source of inputs is the master.
interface scramble_input_ctrl_if;
    logic [10:0] ps2_key;
    logic [15:0] joystick_0;
    logic [15:0] joystick_1;
    logic        no_rotate;
    logic        flush;
    logic [6:0]  ip_1p;
    logic [6:0]  ip_2p;
    logic        ip_coin1;
    logic        ip_coin2;

    modport master (
        output ps2_key, joystick_0, joystick_1, no_rotate, flush,
        input  ip_1p, ip_2p, ip_coin1, ip_coin2
    );

    modport slave (
        input  ps2_key, joystick_0, joystick_1, no_rotate, flush,
        output ip_1p, ip_2p, ip_coin1, ip_coin2
    );
endinterface

// File: rtl/scramble_input_ctrl_coin.sv
// Coin pulse generator: one pulse per fresh press, fixed width, then a lockout gap.
// A press that is still held when the gap ends parks in HOLD until released.
module coin_pulse_gen
    import scramble_input_pkg::*;
#(
    parameter int COIN_PULSE = 4,
    parameter int COIN_GAP   = 6,
    parameter int CNT_W      = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ce,
    input  logic flush,
    input  logic req,
    output logic coin
);

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(COIN_PULSE - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(COIN_GAP - 1);

    logic        req_d, req_q;
    logic        prev_d, prev_q;
    logic        req_rise;
    coin_state_e state_q;
    logic [CNT_W-1:0] cnt_q;
    logic        coin_q;

    // Flush marks the request as already seen, so a held button needs a release first.
    always_comb begin
        req_d  = req;
        prev_d = req_q;
        if (flush) begin
            req_d  = 1'b1;
            prev_d = 1'b1;
        end
    end

    assign req_rise = req_q & ~prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q  <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            req_q  <= req_d;
            prev_q <= prev_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            coin_q  <= 1'b0;
        end else if (flush) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            coin_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_rise) begin
                        state_q <= ST_PULSE;
                        cnt_q   <= PULSE_LOAD;
                        coin_q  <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (ce) begin
                        if (cnt_q == '0) begin
                            state_q <= ST_GAP;
                            cnt_q   <= GAP_LOAD;
                            coin_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (ce) begin
                        if (cnt_q == '0) begin
                            state_q <= req_q ? ST_HOLD : ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (!req_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign coin = coin_q;

endmodule

// File: rtl/scramble_input_ctrl.sv
// Input-conditioning stage for the Scramble core: PS/2 decode, joystick merge,
// rotation remap, active-low player words and timed coin pulses.
module scramble_input_ctrl
    import scramble_input_pkg::*;
#(
    parameter int COIN_PULSE = 4,
    parameter int COIN_GAP   = 6,
    parameter int CNT_W      = 4
) (
    input  logic                 clk_sys,
    input  logic                 RESET_N,
    input  logic                 ce,
    scramble_input_ctrl_if.slave bus
);

    logic       toggle_d, toggle_q;
    held_keys_t keys_d, keys_q;
    logic [6:0] ip_1p_d, ip_1p_q;
    logic [6:0] ip_2p_d, ip_2p_q;
    logic [8:0] joy_any;
    logic [8:0] code;
    logic       pressed;
    logic       key_event;
    logic       req1, req2;

    assign code      = bus.ps2_key[8:0];
    assign pressed   = bus.ps2_key[9];
    assign key_event = bus.ps2_key[10] ^ toggle_q;
    assign joy_any   = bus.joystick_0[8:0] | bus.joystick_1[8:0];

    // Flush beats a simultaneous key event; the event is consumed by the toggle update anyway.
    always_comb begin
        keys_d   = keys_q;
        toggle_d = bus.ps2_key[10];
        if (bus.flush) begin
            keys_d = '0;
        end else if (key_event) begin
            case (code[7:0])
                SC_UP:    keys_d.up    = pressed;
                SC_DOWN:  keys_d.down  = pressed;
                SC_LEFT:  keys_d.left  = pressed;
                SC_RIGHT: keys_d.right = pressed;
                default:  ;
            endcase
            case (code)
                SC_FIRE1:    keys_d.fire1    = pressed;
                SC_FIRE2:    keys_d.fire2    = pressed;
                SC_START1_A: keys_d.start1   = pressed;
                SC_START1_B: keys_d.start1   = pressed;
                SC_START2_A: keys_d.start2   = pressed;
                SC_START2_B: keys_d.start2   = pressed;
                SC_COIN1:    keys_d.coin1    = pressed;
                SC_COIN2:    keys_d.coin2    = pressed;
                SC_P2_UP:    keys_d.p2_up    = pressed;
                SC_P2_DOWN:  keys_d.p2_down  = pressed;
                SC_P2_LEFT:  keys_d.p2_left  = pressed;
                SC_P2_RIGHT: keys_d.p2_right = pressed;
                SC_P2_FIRE1: keys_d.p2_fire1 = pressed;
                SC_P2_FIRE2: keys_d.p2_fire2 = pressed;
                default:     ;
            endcase
        end
    end

    always_comb begin
        ip_1p_d = player_word(keys_q.up    | joy_any[JOY_UP],
                              keys_q.down  | joy_any[JOY_DOWN],
                              keys_q.left  | joy_any[JOY_LEFT],
                              keys_q.right | joy_any[JOY_RIGHT],
                              keys_q.fire1 | joy_any[JOY_FIRE1],
                              keys_q.fire2 | joy_any[JOY_FIRE2],
                              keys_q.start1 | joy_any[JOY_START1],
                              bus.no_rotate);
        ip_2p_d = player_word(keys_q.p2_up    | joy_any[JOY_UP],
                              keys_q.p2_down  | joy_any[JOY_DOWN],
                              keys_q.p2_left  | joy_any[JOY_LEFT],
                              keys_q.p2_right | joy_any[JOY_RIGHT],
                              keys_q.p2_fire1 | joy_any[JOY_FIRE1],
                              keys_q.p2_fire2 | joy_any[JOY_FIRE2],
                              keys_q.start2   | joy_any[JOY_START2],
                              bus.no_rotate);
    end

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            toggle_q <= 1'b0;
            keys_q   <= '0;
            ip_1p_q  <= 7'h7F;
            ip_2p_q  <= 7'h7F;
        end else begin
            toggle_q <= toggle_d;
            keys_q   <= keys_d;
            ip_1p_q  <= ip_1p_d;
            ip_2p_q  <= ip_2p_d;
        end
    end

    assign req1 = keys_q.coin1 | joy_any[JOY_COIN];
    assign req2 = keys_q.coin2;

    coin_pulse_gen #(
        .COIN_PULSE (COIN_PULSE),
        .COIN_GAP   (COIN_GAP),
        .CNT_W      (CNT_W)
    ) u_coin1 (
        .clk   (clk_sys),
        .rst_n (RESET_N),
        .ce    (ce),
        .flush (bus.flush),
        .req   (req1),
        .coin  (bus.ip_coin1)
    );

    coin_pulse_gen #(
        .COIN_PULSE (COIN_PULSE),
        .COIN_GAP   (COIN_GAP),
        .CNT_W      (CNT_W)
    ) u_coin2 (
        .clk   (clk_sys),
        .rst_n (RESET_N),
        .ce    (ce),
        .flush (bus.flush),
        .req   (req2),
        .coin  (bus.ip_coin2)
    );

    assign bus.ip_1p = ip_1p_q;
    assign bus.ip_2p = ip_2p_q;

endmodule

// File: tb/tb_scramble_input_ctrl.sv
// Bench for scramble_input_ctrl: directed scenarios plus random traffic, all
// compared every cycle against a behavioural model of keys, merge and coin timing.
module tb_scramble_input_ctrl;

    localparam int COIN_PULSE = 4;
    localparam int COIN_GAP   = 6;

    // Held-key slots: 0-3 up/down/left/right, 4/5 fire, 6/7 start1/2, 8/9 coin1/2, 10-15 P2 dirs/fires.
    localparam logic [8:0] CODE_TBL [16] = '{9'h075, 9'h072, 9'h06B, 9'h074, 9'h014, 9'h029,
                                             9'h005, 9'h006, 9'h02E, 9'h036, 9'h02D, 9'h02B,
                                             9'h023, 9'h034, 9'h01C, 9'h01B};
    localparam logic [8:0] KEY_POOL [20] = '{9'h075, 9'h072, 9'h06B, 9'h074, 9'h014, 9'h029,
                                             9'h005, 9'h016, 9'h006, 9'h01E, 9'h02E, 9'h036,
                                             9'h02D, 9'h02B, 9'h023, 9'h034, 9'h01C, 9'h01B,
                                             9'h0AA, 9'h0F0};

    logic clk_sys = 1'b0;
    logic RESET_N = 1'b0;
    logic ce      = 1'b0;

    scramble_input_ctrl_if bus();

    scramble_input_ctrl #(
        .COIN_PULSE (COIN_PULSE),
        .COIN_GAP   (COIN_GAP),
        .CNT_W      (4)
    ) dut (
        .clk_sys (clk_sys),
        .RESET_N (RESET_N),
        .ce      (ce),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int checks   = 0;
    int failures = 0;

    bit         m_held [16];
    bit         m_tog;
    bit         m_busy [2];
    bit         m_coin [2];
    bit         m_r1 [2];
    bit         m_r2 [2];
    int         m_ticks [2];
    logic [6:0] exp_1p, exp_2p;

    int ce_period = 0;
    int cyc       = 0;
    int pulses1   = 0;
    int width1    = 0;
    bit prev_c1   = 1'b0;

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic int codeIdx(input logic [8:0] code);
        if (code == 9'h016) return 6;
        if (code == 9'h01E) return 7;
        for (int i = 0; i < 16; i++) begin
            if (i < 4) begin
                if (code[7:0] == CODE_TBL[i][7:0]) return i;
            end else if (code == CODE_TBL[i]) begin
                return i;
            end
        end
        return -1;
    endfunction

    function automatic logic [6:0] expWord(input bit u, input bit d, input bit l, input bit r,
                                           input bit f1, input bit f2, input bit st, input bit rot);
        bit uu, dd, ll, rr;
        if (rot) begin
            uu = l; dd = r; ll = d; rr = u;
        end else begin
            uu = u; dd = d; ll = l; rr = r;
        end
        return ~{st, f2, f1, ll, rr, uu, dd};
    endfunction

    task automatic modelReset();
        foreach (m_held[i]) m_held[i] = 1'b0;
        m_tog = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 1'b0; m_coin[i] = 1'b0; m_r1[i] = 1'b0; m_r2[i] = 1'b0; m_ticks[i] = 0;
        end
        exp_1p = 7'h7F;
        exp_2p = 7'h7F;
    endtask

    // Advance one clock: predict the post-edge outputs from pre-edge inputs, then compare.
    task automatic tick();
        logic [15:0] ja;
        bit req [2];
        int idx;
        if (ce_period > 0) ce = ((cyc % ce_period) == 0);
        else               ce = ($urandom_range(0, 2) == 0);
        cyc++;
        ja = bus.joystick_0 | bus.joystick_1;
        exp_1p = expWord(m_held[0] | ja[3], m_held[1] | ja[2], m_held[2] | ja[1], m_held[3] | ja[0],
                         m_held[4] | ja[4], m_held[5] | ja[5], m_held[6] | ja[6], bus.no_rotate);
        exp_2p = expWord(m_held[10] | ja[3], m_held[11] | ja[2], m_held[12] | ja[1], m_held[13] | ja[0],
                         m_held[14] | ja[4], m_held[15] | ja[5], m_held[7] | ja[7], bus.no_rotate);
        req[0] = m_held[8] | ja[8];
        req[1] = m_held[9];
        for (int i = 0; i < 2; i++) begin
            if (bus.flush) begin
                m_busy[i] = 1'b0; m_coin[i] = 1'b0; m_r1[i] = 1'b1; m_r2[i] = 1'b1;
            end else begin
                if (!m_busy[i]) begin
                    if (m_r1[i] && !m_r2[i]) begin
                        m_busy[i] = 1'b1; m_coin[i] = 1'b1; m_ticks[i] = 0;
                    end
                end else if (ce) begin
                    m_ticks[i]++;
                    if (m_ticks[i] == COIN_PULSE) m_coin[i] = 1'b0;
                    if (m_ticks[i] == COIN_PULSE + COIN_GAP) m_busy[i] = 1'b0;
                end
                m_r2[i] = m_r1[i];
                m_r1[i] = req[i];
            end
        end
        if (bus.flush) begin
            foreach (m_held[i]) m_held[i] = 1'b0;
        end else if (bus.ps2_key[10] != m_tog) begin
            idx = codeIdx(bus.ps2_key[8:0]);
            if (idx >= 0) m_held[idx] = bus.ps2_key[9];
        end
        m_tog = bus.ps2_key[10];
        @(posedge clk_sys);
        #1;
        checkOutput("ip_1p", 16'(bus.ip_1p), 16'(exp_1p));
        checkOutput("ip_2p", 16'(bus.ip_2p), 16'(exp_2p));
        checkOutput("ip_coin1", 16'(bus.ip_coin1), 16'(m_coin[0]));
        checkOutput("ip_coin2", 16'(bus.ip_coin2), 16'(m_coin[1]));
        if (bus.ip_coin1 && !prev_c1) pulses1++;
        if (bus.ip_coin1) width1++;
        prev_c1 = bus.ip_coin1;
    endtask

    task automatic sendKey(input logic [8:0] code, input bit pressed);
        bus.ps2_key = {~bus.ps2_key[10], pressed, code};
        tick();
    endtask

    // Random traffic: key events (listed, unlisted, extended-prefixed), joysticks, rotate, flush.
    task automatic applyStimulus(input int n);
        logic [8:0] code;
        for (int k = 0; k < n; k++) begin
            bus.flush = 1'b0;
            if ($urandom_range(0, 5) == 0) begin
                code = KEY_POOL[$urandom_range(0, 19)];
                if ($urandom_range(0, 3) == 0) code[8] = 1'b1;
                bus.ps2_key = {~bus.ps2_key[10], 1'($urandom_range(0, 1)), code};
            end
            if ($urandom_range(0, 19) == 0) begin
                bus.joystick_0 = (16'($urandom) & 16'hFE00) |
                                 ($urandom_range(0, 1) ? (16'h1 << $urandom_range(0, 8)) : 16'h0);
            end
            if ($urandom_range(0, 29) == 0) begin
                bus.joystick_1 = (16'($urandom) & 16'hFE00) |
                                 ($urandom_range(0, 2) == 0 ? (16'h1 << $urandom_range(0, 8)) : 16'h0);
            end
            if ($urandom_range(0, 39) == 0) bus.no_rotate = ~bus.no_rotate;
            if ($urandom_range(0, 79) == 0) bus.flush = 1'b1;
            tick();
        end
        bus.flush = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.ps2_key    = '0;
        bus.joystick_0 = '0;
        bus.joystick_1 = '0;
        bus.no_rotate  = 1'b0;
        bus.flush      = 1'b0;
        modelReset();

        repeat (3) @(posedge clk_sys);
        #1;
        checkOutput("rst_ip_1p", 16'(bus.ip_1p), 16'h007F);
        checkOutput("rst_ip_2p", 16'(bus.ip_2p), 16'h007F);
        checkOutput("rst_coin1", 16'(bus.ip_coin1), 16'h0000);
        checkOutput("rst_coin2", 16'(bus.ip_coin2), 16'h0000);
        @(negedge clk_sys);
        RESET_N = 1'b1;
        repeat (100) tick();
        checkOutput("idle_ip_1p", 16'(bus.ip_1p), 16'h007F);

        $display("[TB] keyboard decode");
        sendKey(9'h075, 1'b1);
        tick();
        checkOutput("kb_up_press", 16'(bus.ip_1p), 16'h007D);
        sendKey(9'h075, 1'b0);
        tick();
        checkOutput("kb_up_release", 16'(bus.ip_1p), 16'h007F);
        sendKey(9'h175, 1'b1);
        tick();
        checkOutput("kb_ext_up_press", 16'(bus.ip_1p), 16'h007D);
        sendKey(9'h175, 1'b0);
        tick();

        $display("[TB] rotate remap");
        bus.no_rotate  = 1'b1;
        bus.joystick_0 = 16'h0002;
        tick();
        checkOutput("rot_left_to_up", 16'(bus.ip_1p), 16'h007D);
        bus.no_rotate = 1'b0;
        tick();
        checkOutput("norot_left", 16'(bus.ip_1p), 16'h0077);
        bus.joystick_0 = 16'h0000;
        tick();

        $display("[TB] coin timing");
        ce_period = 4;
        pulses1 = 0; width1 = 0;
        bus.joystick_0 = 16'h0100;
        repeat (200) tick();
        checkOutput("coin_held_pulses", 16'(pulses1), 16'd1);
        checkOutput("coin_width_ok", 16'(width1 >= 12 && width1 <= 20), 16'd1);
        bus.joystick_0 = 16'h0000;
        repeat (5) tick();
        pulses1 = 0;
        bus.joystick_0 = 16'h0100;
        repeat (40) tick();
        checkOutput("coin_repress_pulses", 16'(pulses1), 16'd1);
        bus.joystick_0 = 16'h0000;
        repeat (30) tick();

        $display("[TB] coin lockout");
        pulses1 = 0;
        bus.joystick_0 = 16'h0100;
        repeat (3) tick();
        bus.joystick_0 = 16'h0000;
        for (int i = 0; i < 100 && bus.ip_coin1; i++) tick();
        checkOutput("coin1_fell", 16'(bus.ip_coin1), 16'd0);
        repeat (2) tick();
        bus.joystick_0 = 16'h0100;
        repeat (2) tick();
        bus.joystick_0 = 16'h0000;
        repeat (40) tick();
        checkOutput("lockout_dropped", 16'(pulses1), 16'd1);
        bus.joystick_0 = 16'h0100;
        repeat (10) tick();
        checkOutput("after_lockout_idle", 16'(pulses1), 16'd2);
        bus.joystick_0 = 16'h0000;
        repeat (30) tick();

        $display("[TB] flush collision");
        sendKey(9'h036, 1'b1);
        for (int i = 0; i < 20 && !bus.ip_coin2; i++) tick();
        checkOutput("coin2_started", 16'(bus.ip_coin2), 16'd1);
        tick();
        bus.ps2_key = {~bus.ps2_key[10], 1'b1, 9'h014};
        bus.flush   = 1'b1;
        tick();
        bus.flush = 1'b0;
        checkOutput("flush_coin2", 16'(bus.ip_coin2), 16'd0);
        tick();
        checkOutput("flush_fire1", 16'(bus.ip_1p[4]), 16'd1);
        sendKey(9'h036, 1'b1);
        repeat (3) tick();
        checkOutput("coin2_after_flush", 16'(bus.ip_coin2), 16'd1);
        sendKey(9'h036, 1'b0);
        repeat (40) tick();

        $display("[TB] async reset mid-pulse");
        bus.joystick_0 = 16'h0100;
        repeat (6) tick();
        checkOutput("coin1_prereset", 16'(bus.ip_coin1), 16'd1);
        #2;
        RESET_N = 1'b0;
        #1;
        checkOutput("coin1_async_rst", 16'(bus.ip_coin1), 16'd0);
        checkOutput("ip_1p_async_rst", 16'(bus.ip_1p), 16'h007F);
        bus.joystick_0 = 16'h0000;
        modelReset();
        @(negedge clk_sys);
        RESET_N = 1'b1;
        repeat (5) tick();

        $display("[TB] random traffic");
        ce_period = 0;
        applyStimulus(2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
